ones_count7: RTL and testbench

- Registered 7-input population counter: counts the 1-bits on a 7-bit input vector and presents the count (0..7) as a 3-bit binary value one clock later.
- Contains two independent datapaths:
  - a structural full-adder tree, which drives the output;
  - a behavioural arithmetic sum, used as a built-in self-check.
- Used wherever a ones-count or majority/threshold decision of 7 bits is needed.

---
 rtl/ones_count7.sv | 104 ++++++++++
 tb/tb_ones_count7.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ones_count7.sv
// ones_count7: registered 7-input population counter.
// The output count comes from a full-adder tree. A separate arithmetic sum of
// the same bits cross-checks that tree, and any disagreement raises a sticky
// mismatch flag.

// One-bit full adder built from XOR/AND/OR gates.
module ones_count7_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    // Sum and majority carry.
    always_comb begin
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
    end

endmodule

module ones_count7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [0:6] i,
    output logic [2:0] y,
    output logic       y_valid,
    output logic       mismatch
);

    localparam int unsigned IN_W  = 7;
    localparam int unsigned CNT_W = 3;

    logic             s_a;
    logic             c_a;
    logic             s_b;
    logic             c_b;
    logic             c_c;
    logic [CNT_W-1:0] cnt_gl;
    logic [CNT_W-1:0] cnt_as;

    // First level: two independent groups of three input bits.
    ones_count7_fa fa_a (
        .a  (i[0]),
        .b  (i[1]),
        .c  (i[2]),
        .s  (s_a),
        .co (c_a)
    );

    ones_count7_fa fa_b (
        .a  (i[3]),
        .b  (i[4]),
        .c  (i[5]),
        .s  (s_b),
        .co (c_b)
    );

    // Weight-1 column: the two partial sums plus the seventh bit.
    ones_count7_fa fa_c (
        .a  (s_a),
        .b  (s_b),
        .c  (i[6]),
        .s  (cnt_gl[0]),
        .co (c_c)
    );

    // Weight-2 column: its carry out forms the weight-4 bit.
    ones_count7_fa fa_d (
        .a  (c_a),
        .b  (c_b),
        .c  (c_c),
        .s  (cnt_gl[1]),
        .co (cnt_gl[2])
    );

    // Arithmetic reference count. A 3-bit sum cannot overflow because the
    // maximum is 7.
    always_comb begin
        cnt_as = '0;
        for (int unsigned k = 0; k < IN_W; k++) begin
            cnt_as = cnt_as + CNT_W'(i[k]);
        end
    end

    // Output registers. y holds while the input is idle. mismatch stays set
    // once raised and clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= '0;
            y_valid  <= 1'b0;
            mismatch <= 1'b0;
        end else if (in_valid) begin
            y        <= cnt_gl;
            y_valid  <= 1'b1;
            mismatch <= mismatch | (cnt_gl != cnt_as);
        end else begin
            y_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ones_count7.sv
// Directed testbench for ones_count7. Expected counts are worked out by hand
// for the directed steps and computed in the bench for the exhaustive sweep.
module tb_ones_count7;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [0:6] i;
    logic [2:0] y;
    logic       y_valid;
    logic       mismatch;

    int tests;
    int fails;

    ones_count7 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .i        (i),
        .y        (y),
        .y_valid  (y_valid),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, then wait for the next falling edge. A rising edge falls
    // in between, so the outputs that follow can be sampled mid-cycle.
    task automatic cycle(input logic r, input logic v, input logic [6:0] vec);
        rst      = r;
        in_valid = v;
        i        = vec;
        @(negedge clk);
    endtask

    // Compare all three outputs against the given expectations.
    task automatic check(input string tag, input logic [2:0] ey, input logic ev,
                         input logic em);
        tests++;
        assert (y === ey) else begin
            fails++;
            $error("FAIL %s: y=%b expected %b", tag, y, ey);
        end
        tests++;
        assert (y_valid === ev) else begin
            fails++;
            $error("FAIL %s: y_valid=%b expected %b", tag, y_valid, ev);
        end
        tests++;
        assert (mismatch === em) else begin
            fails++;
            $error("FAIL %s: mismatch=%b expected %b", tag, mismatch, em);
        end
    endtask

    logic [6:0] thermo [8];
    logic [2:0] prev_y;

    initial begin
        tests = 0;
        fails = 0;

        // Reset takes priority over valid input.
        cycle(1'b1, 1'b1, 7'b1111111);
        check("reset_1", 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 7'b1111111);
        check("reset_2", 3'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 7'b1111111);
        check("reset_release", 3'd7, 1'b1, 1'b0);

        // Thermometer sweep.
        thermo = '{7'b0000000, 7'b0000001, 7'b0000011, 7'b0000111,
                   7'b0001111, 7'b0011111, 7'b0111111, 7'b1111111};
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, thermo[k]);
            check($sformatf("thermo_%0d", k), 3'(k), 1'b1, 1'b0);
        end

        // Single-bit sensitivity on each output bit.
        cycle(1'b0, 1'b1, 7'b1111111);
        check("bit0_hi", 3'd7, 1'b1, 1'b0);
        prev_y = y;
        cycle(1'b0, 1'b1, 7'b1111110);
        check("bit0_lo", 3'd6, 1'b1, 1'b0);
        tests++;
        assert ((prev_y ^ y) === 3'b001) else begin
            fails++;
            $error("FAIL bit0_toggle: toggled=%b expected 001", prev_y ^ y);
        end

        cycle(1'b0, 1'b1, 7'b0001110);
        check("bit1_a", 3'd3, 1'b1, 1'b0);
        prev_y = y;
        cycle(1'b0, 1'b1, 7'b0011110);
        check("bit1_b", 3'd4, 1'b1, 1'b0);
        tests++;
        assert ((prev_y ^ y) === 3'b111) else begin
            fails++;
            $error("FAIL bit1_toggle: toggled=%b expected 111", prev_y ^ y);
        end

        cycle(1'b0, 1'b1, 7'b1100011);
        check("bit2_a", 3'd4, 1'b1, 1'b0);
        prev_y = y;
        cycle(1'b0, 1'b1, 7'b1100001);
        check("bit2_b", 3'd3, 1'b1, 1'b0);
        tests++;
        assert ((prev_y ^ y) === 3'b111) else begin
            fails++;
            $error("FAIL bit2_toggle: toggled=%b expected 111", prev_y ^ y);
        end

        // Reference vectors that depend on bit position.
        cycle(1'b0, 1'b1, 7'b1101111);
        check("ref_1101111", 3'd6, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 7'b1100000);
        check("ref_1100000", 3'd2, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 7'b1110001);
        check("ref_1110001", 3'd4, 1'b1, 1'b0);

        // Hold: an idle input leaves y unchanged.
        cycle(1'b0, 1'b1, 7'b1101110);
        check("hold_load", 3'd5, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 7'b0000000);
            check($sformatf("hold_%0d", k), 3'd5, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b1, 7'b1001000);
        check("hold_resume", 3'd2, 1'b1, 1'b0);

        // Exhaustive back-to-back sweep, with a reset injected mid-stream.
        for (int k = 0; k < 128; k++) begin
            logic [6:0] v;
            v = 7'(k);
            if (k == 64) begin
                cycle(1'b1, 1'b1, v);
                check("midstream_reset", 3'd0, 1'b0, 1'b0);
            end else begin
                cycle(1'b0, 1'b1, v);
                check($sformatf("exh_%0d", k), 3'($countones(v)), 1'b1, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
